// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM state type and SPI edge-select helpers for spi_reg_slave
package spi_reg_pkg;
  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
  // sample on rising sclk when CPOL==CPHA, falling otherwise; shift uses the other edge
  function automatic logic sample_edge(input int cpol, input int cpha);
    return ((cpol != 0) == (cpha != 0)) ? EDGE_RISE : EDGE_FALL;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with change detection for one async input
// ports: clk, reset (async, high); i_d raw input; o_q synchronised level; o_edge one-clk pulse on any change of o_q
module spi_sync_edge
  import spi_reg_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);
  logic [STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync <= {STAGES{RST_LVL}};
      r_prev <= RST_LVL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_q = r_sync[STAGES-1];
  assign o_edge = o_q ^ r_prev;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave bridging R/W + address + burst data frames onto a simple register bus
// ports: clk, reset (async, high); sclk/cs_n/mosi raw SPI pins; miso/miso_oe serial out and enable;
//        wr_en/wr_addr/wr_data write strobe; rd_req/rd_addr read request, rd_data valid 1 clk after rd_req;
//        busy frame in progress; frame_err one-clk pulse on a frame aborted mid-field
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);
  localparam logic SAMPLE_EDGE = sample_edge(CPOL, CPHA);
  localparam logic SCLK_IDLE = CPOL != 0;
  localparam int CW = $clog2(DATA_W > ADDR_W ? DATA_W : ADDR_W) + 1;
  logic w_sclk, w_sclk_e, w_cs, w_cs_e, w_mosi, w_sample, w_shift, w_last;
  logic [SYNC_STAGES-1:0] r_mosi;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_rw, r_load, r_miso, r_wr_en, r_rd_req, r_ferr;
  logic [ADDR_W-1:0] r_addr, r_wr_addr, r_rd_addr, w_addr_in;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx, r_wr_data, w_word_in;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(SCLK_IDLE)) u_sclk (
    .clk(clk), .reset(reset), .i_d(sclk), .o_q(w_sclk), .o_edge(w_sclk_e));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .i_d(cs_n), .o_q(w_cs), .o_edge(w_cs_e));
  // mosi shares the synchroniser depth so it lines up with the detected sclk edge
  always_ff @(posedge clk or posedge reset)
    if (reset) r_mosi <= '0;
    else r_mosi <= {r_mosi[SYNC_STAGES-2:0], mosi};
  assign w_mosi = r_mosi[SYNC_STAGES-1];
  assign w_sample = w_sclk_e & ~w_cs & (w_sclk == SAMPLE_EDGE);
  assign w_shift = w_sclk_e & ~w_cs & (w_sclk != SAMPLE_EDGE);
  assign w_addr_in = {r_addr[ADDR_W-2:0], w_mosi};
  assign w_word_in = {r_rx, w_mosi};
  always_comb begin
    w_last = w_sample & ((r_state == CMD) | ((r_state == ADDR) & (r_cnt == CW'(ADDR_W - 1))) |
                         ((r_state == DATA) & (r_cnt == CW'(DATA_W - 1))));
    w_next = w_cs ? IDLE : (r_state == IDLE) ? (w_cs_e ? CMD : IDLE) :
             w_last ? ((r_state == CMD) ? ADDR : DATA) : r_state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_rw <= 1'b0;
      r_load <= 1'b0;
      r_miso <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_req <= 1'b0;
      r_ferr <= 1'b0;
      r_addr <= '0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_rx <= '0;
      r_tx <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_req <= 1'b0;
      // only a deselect that leaves a field half-received counts as an abort
      r_ferr <= w_cs & w_cs_e & ((r_state == ADDR) | ((r_state == DATA) & (r_cnt != '0)));
      r_load <= r_rd_req;
      if (r_load) r_tx <= rd_data;
      if (w_cs) begin
        r_cnt <= '0;
        r_rw <= 1'b0;
        r_miso <= 1'b0;
      end else if (w_sample & (r_state != IDLE)) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (r_state == CMD) r_rw <= w_mosi;
        if (r_state == ADDR) r_addr <= w_addr_in;
        if (r_state == DATA) r_rx <= w_word_in[DATA_W-2:0];
        if (w_last & (r_state == ADDR) & r_rw) begin
          r_rd_req <= 1'b1;
          r_rd_addr <= w_addr_in;
        end
        if (w_last & (r_state == DATA)) begin
          r_addr <= r_addr + 1'b1;
          r_rd_req <= r_rw;
          r_wr_en <= ~r_rw;
          if (r_rw) r_rd_addr <= r_addr + 1'b1;
          else begin
            r_wr_addr <= r_addr;
            r_wr_data <= w_word_in;
          end
        end
      end else if (w_shift & (r_state == DATA) & r_rw) begin
        r_miso <= r_tx[DATA_W-1];
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  assign miso = r_miso;
  assign miso_oe = ~w_cs;
  assign wr_en = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_req = r_rd_req;
  assign rd_addr = r_rd_addr;
  assign busy = r_state != IDLE;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed self-checking bench over four SPI mode/width configurations
`timescale 1ns/1ps
module tb_spi_reg_slave;
  localparam int AW [4] = '{4, 4, 8, 8};
  localparam int DW [4] = '{8, 8, 32, 32};
  localparam int PL [4] = '{0, 1, 0, 1};
  localparam int PH [4] = '{0, 1, 1, 0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk [4];
  logic cs_n [4];
  logic mosi [4];
  logic miso [4];
  logic oe [4];
  logic wr_en [4];
  logic rd_req [4];
  logic busy [4];
  logic ferr [4];
  logic [7:0] wr_addr [4];
  logic [7:0] rd_addr [4];
  logic [31:0] wr_data [4];
  logic [31:0] bank [256];
  logic [7:0] wa_q [$];
  logic [7:0] ra_q [$];
  logic [31:0] wd_q [$];
  int n_err = 0;
  int total = 0;
  int bad = 0;
  int sel = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 4; i++) begin : g_dut
    logic [AW[i]-1:0] wa, ra;
    logic [DW[i]-1:0] wd, rdd;
    spi_reg_slave #(.ADDR_W(AW[i]), .DATA_W(DW[i]), .CPOL(PL[i]), .CPHA(PH[i]), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[i]), .cs_n(cs_n[i]), .mosi(mosi[i]),
      .miso(miso[i]), .miso_oe(oe[i]), .wr_en(wr_en[i]), .wr_addr(wa), .wr_data(wd),
      .rd_req(rd_req[i]), .rd_addr(ra), .rd_data(rdd), .busy(busy[i]), .frame_err(ferr[i]));
    assign wr_addr[i] = 8'(wa);
    assign rd_addr[i] = 8'(ra);
    assign wr_data[i] = 32'(wd);
    always @(posedge clk) rdd <= bank[8'(ra)][DW[i]-1:0];
  end
  always @(negedge clk) begin
    if (wr_en[sel]) begin
      wa_q.push_back(wr_addr[sel]);
      wd_q.push_back(wr_data[sel]);
      bank[wr_addr[sel]] <= wr_data[sel];
    end
    if (rd_req[sel]) ra_q.push_back(rd_addr[sel]);
    if (ferr[sel]) n_err <= n_err + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int d, input int n, input logic [63:0] tx, output logic [63:0] rx);
    rx = '0;
    for (int b = n - 1; b >= 0; b--) begin
      if (PH[d] == 0) begin
        mosi[d] = tx[b];
        tick(8);
        rx[b] = miso[d];
        sclk[d] = PL[d] == 0;
        tick(8);
        sclk[d] = PL[d] != 0;
      end else begin
        sclk[d] = PL[d] == 0;
        mosi[d] = tx[b];
        tick(8);
        rx[b] = miso[d];
        sclk[d] = PL[d] != 0;
        tick(8);
      end
    end
  endtask
  task automatic frame(input int d, input int n, input logic [63:0] tx, output logic [63:0] rx);
    sel = d;
    tick(8);
    cs_n[d] = 1'b0;
    tick(8);
    xfer(d, n, tx, rx);
    tick(8);
    cs_n[d] = 1'b1;
    tick(12);
  endtask
  logic [63:0] rx;
  int w0, r0, e0;
  initial begin
    for (int d = 0; d < 4; d++) begin
      sclk[d] = PL[d] != 0;
      cs_n[d] = 1'b1;
      mosi[d] = 1'b0;
    end
    tick(4);
    chk("rst_out", {busy[0], miso[0], oe[0], wr_en[0], rd_req[0], ferr[0], wr_addr[0], wr_data[0], rd_addr[0]}, '0);
    reset = 1'b0;
    tick(4);
    chk("idle", {busy[0], oe[0], busy[3], oe[3]}, '0);
    // single write, mode 0
    w0 = wa_q.size(); r0 = ra_q.size(); e0 = n_err;
    frame(0, 13, 64'h05A5, rx);
    chk("w_cnt", wa_q.size() - w0, 1);
    chk("w_addr", wa_q[w0], 8'h5);
    chk("w_data", wd_q[w0], 32'hA5);
    chk("w_miso", rx, 0);
    chk("w_noerr", n_err - e0, 0);
    chk("w_nord", ra_q.size() - r0, 0);
    chk("w_busy", busy[0], 0);
    // write burst wrapping 0xF -> 0x0
    w0 = wa_q.size();
    frame(0, 21, 64'hF1122, rx);
    chk("b_cnt", wa_q.size() - w0, 2);
    chk("b_addr0", wa_q[w0], 8'hF);
    chk("b_data0", wd_q[w0], 32'h11);
    chk("b_addr1", wa_q[w0+1], 8'h0);
    chk("b_data1", wd_q[w0+1], 32'h22);
    // abort after 5 data bits
    w0 = wa_q.size(); e0 = n_err;
    tick(8);
    cs_n[0] = 1'b0;
    tick(8);
    xfer(0, 10, 64'h0B4, rx);
    tick(8);
    chk("ab_busy1", busy[0], 1);
    cs_n[0] = 1'b1;
    tick(4);
    chk("ab_busy0", busy[0], 0);
    tick(8);
    chk("ab_err", n_err - e0, 1);
    chk("ab_nowr", wa_q.size() - w0, 0);
    // reset in the address phase
    w0 = wa_q.size(); e0 = n_err;
    tick(8);
    cs_n[0] = 1'b0;
    tick(8);
    xfer(0, 3, 64'h1, rx);
    tick(4);
    chk("rs_pre", {busy[0], oe[0]}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rs_out", {busy[0], miso[0], oe[0], wr_en[0], rd_req[0], ferr[0], wr_addr[0], wr_data[0], rd_addr[0]}, '0);
    cs_n[0] = 1'b1;
    tick(8);
    reset = 1'b0;
    tick(8);
    chk("rs_quiet", {32'(wa_q.size() - w0), 32'(n_err - e0)}, 0);
    frame(0, 13, 64'h075A, rx);
    chk("rs_cnt", wa_q.size() - w0, 1);
    chk("rs_addr", wa_q[w0], 8'h7);
    chk("rs_data", wd_q[w0], 32'h5A);
    // mode 3 burst read of addr 3/4 after preloading through the bus
    frame(1, 21, 64'h33CC3, rx);
    w0 = wa_q.size(); r0 = ra_q.size();
    frame(1, 21, 64'h130000, rx);
    chk("r_data", rx & 64'hFFFF, 64'h3CC3);
    chk("r_hdr0", rx >> 16, 0);
    chk("r_reqs", ra_q.size() - r0 >= 2, 1);
    chk("r_addr0", ra_q[r0], 8'h3);
    chk("r_addr1", ra_q[r0+1], 8'h4);
    chk("r_nowr", wa_q.size() - w0, 0);
    // modes 1 and 2, 8-bit address, 32-bit data
    for (int d = 2; d < 4; d++) begin
      w0 = wa_q.size();
      frame(d, 41, 64'h80DEADBEEF, rx);
      chk($sformatf("m%0d_wcnt", PL[d] * 2 + PH[d]), wa_q.size() - w0, 1);
      chk($sformatf("m%0d_waddr", PL[d] * 2 + PH[d]), wa_q[w0], 8'h80);
      chk($sformatf("m%0d_wdata", PL[d] * 2 + PH[d]), wd_q[w0], 32'hDEADBEEF);
      r0 = ra_q.size();
      frame(d, 41, 64'h18000000000, rx);
      chk($sformatf("m%0d_rdata", PL[d] * 2 + PH[d]), rx & 64'hFFFFFFFF, 64'hDEADBEEF);
      chk($sformatf("m%0d_raddr", PL[d] * 2 + PH[d]), ra_q[r0], 8'h80);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
